// File: rtl/idct_stream_arbiter.sv
// rtl/idct_stream_arbiter.sv - round-robin block arbiter sharing one IDCT stream core between N requesters
// Purpose: grants the core input to one requester per 64-coefficient block, remembers the block
//          owner in a tag FIFO, and routes each 64-sample output block back to its owner in order.
// Ports:   clock, reset_n           clock and asynchronous active-low reset
//          s_tdata/s_tvalid/s_tready     per-requester coefficient streams (channel k at slice k)
//          core_s_tdata/_tvalid/_tready  stream into the IDCT core
//          core_m_tdata/_tvalid/_tready  stream out of the IDCT core
//          m_tdata/m_tvalid/m_tready     shared result data, one-hot valid, per-channel ready
//          busy                          grant active or blocks outstanding
//          err_orphan                    sticky: core produced output with no owner recorded
//          prio                          (only with IDCT_ARB_PRIO_EN) per-channel priority request
// Macro:   IDCT_ARB_PRIO_EN adds the prio input; undefined gives pure round-robin.
`ifndef WIN
`define WIN 12
`endif
`ifndef WOUT
`define WOUT 9
`endif

module idct_stream_arbiter #(
    parameter int N         = 4,
    parameter int IDW       = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
`ifdef IDCT_ARB_PRIO_EN
    input  logic [N-1:0]          prio,
`endif
    input  logic [N*`WIN-1:0]     s_tdata,
    input  logic [N-1:0]          s_tvalid,
    output logic [N-1:0]          s_tready,
    output logic [`WIN-1:0]       core_s_tdata,
    output logic                  core_s_tvalid,
    input  logic                  core_s_tready,
    input  logic [`WOUT-1:0]      core_m_tdata,
    input  logic                  core_m_tvalid,
    output logic                  core_m_tready,
    output logic [`WOUT-1:0]      m_tdata,
    output logic [N-1:0]          m_tvalid,
    input  logic [N-1:0]          m_tready,
    output logic                  busy,
    output logic                  err_orphan
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  gnt_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [5:0]      in_cnt_q;
    logic [5:0]      out_cnt_q;
    logic [IDW-1:0]  tag_mem_q [TAG_DEPTH];
    logic [PW:0]     wr_ptr_q, rd_ptr_q;
    logic            err_orphan_q;

    logic            fifo_empty, fifo_full;
    logic [IDW-1:0]  head;
    logic [N-1:0]    req;
    logic            sel_found;
    logic [IDW-1:0]  sel_idx, cand, rr_next;
    logic            grant_take, in_hs, out_hs, pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = tag_mem_q[rd_ptr_q[PW-1:0]];

    // Round-robin search: walk offsets from the far end down so offset 0 (rr_ptr) wins last.
    always_comb begin
        req = s_tvalid;
`ifdef IDCT_ARB_PRIO_EN
        if (|(s_tvalid & prio)) begin
            req = s_tvalid & prio;
        end
`endif
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_ptr_q) + i) % N);
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        rr_next = IDW'((int'(sel_idx) + 1) % N);
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the full check uses the registered count, so a same-cycle pop
    // does not unblock the grant until the following cycle.
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && sel_found) begin
                    grant_take = 1'b1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (in_hs && (in_cnt_q == 6'd63)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the granted channel is wired straight through to the core input.
    always_comb begin
        s_tready      = '0;
        core_s_tvalid = 1'b0;
        core_s_tdata  = '0;
        if (state_q == XFER) begin
            s_tready[gnt_q] = core_s_tready;
            core_s_tvalid   = s_tvalid[gnt_q];
            core_s_tdata    = s_tdata[gnt_q*`WIN +: `WIN];
        end
        in_hs = core_s_tvalid & core_s_tready;
    end

    // Output routing follows the oldest outstanding tag, purely combinational.
    always_comb begin
        m_tvalid      = '0;
        m_tdata       = '0;
        core_m_tready = 1'b0;
        out_hs        = 1'b0;
        if (!fifo_empty) begin
            m_tvalid[head] = core_m_tvalid;
            m_tdata        = core_m_tdata;
            core_m_tready  = m_tready[head];
            out_hs         = core_m_tvalid & m_tready[head];
        end
        pop = out_hs && (out_cnt_q == 6'd63);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            if (grant_take) begin
                gnt_q                        <= sel_idx;
                rr_ptr_q                     <= rr_next;
                tag_mem_q[wr_ptr_q[PW-1:0]]  <= sel_idx;
                wr_ptr_q                     <= wr_ptr_q + PTR_ONE;
            end
            if (in_hs) begin
                in_cnt_q <= in_cnt_q + 6'd1;
            end
            if (out_hs) begin
                out_cnt_q <= out_cnt_q + 6'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (core_m_tvalid && fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    assign busy       = (state_q == XFER) | !fifo_empty;
    assign err_orphan = err_orphan_q;

endmodule

// File: doc/idct_stream_arbiter.md
Name: idct_stream_arbiter

Overview:
- Shares one AXI-stream IDCT core between N requesters.
- Grants the core input to one requester for a whole 64-coefficient block, using round-robin.
- Records the owner of each block in a tag FIFO, and routes the core's 64-sample output blocks back to the matching requester in order.
- Sits between the per-channel decoder front-ends and the single stream-wrapped IDCT instance.

Parameters:
- N, 4, number of requester channels (2..8).
- IDW, 2, channel-id width; must satisfy 2**IDW >= N.
- TAG_DEPTH, 4, tag FIFO depth (power of two, >= 2); maximum number of blocks granted but not yet fully returned.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- s_tdata  in  N*`WIN  requester coefficients; channel k occupies bits [(k+1)*`WIN-1 : k*`WIN].
- s_tvalid  in  N  per-requester valid.
- s_tready  out  N  per-requester ready.
- core_s_tdata  out  `WIN  to IDCT slave data.
- core_s_tvalid  out  1  to IDCT slave valid.
- core_s_tready  in  1  from IDCT slave ready.
- core_m_tdata  in  `WOUT  from IDCT master data.
- core_m_tvalid  in  1  from IDCT master valid.
- core_m_tready  out  1  to IDCT master ready.
- m_tdata  out  `WOUT  shared result data for all channels.
- m_tvalid  out  N  one-hot result valid.
- m_tready  in  N  per-channel result ready.
- busy  out  1  high when a grant is active or the tag FIFO is non-empty.
- err_orphan  out  1  sticky flag: core output seen with no tag.

Behaviour:
- Reset:
  - The asynchronous assert clears the FSM to IDLE, in_cnt=0, out_cnt=0, rr_ptr=0, the tag FIFO to empty and err_orphan to 0.
  - All outputs reset to 0.
  - A partial block is discarded; the integrator resets the IDCT core on the same reset_n.
- Input FSM, IDLE state:
  - If the tag FIFO is not full and any s_tvalid is high, select the first valid channel searching upward from rr_ptr, wrapping at N.
  - Register the selection as gnt, push gnt into the tag FIFO, set rr_ptr=(gnt+1) mod N, then go to XFER.
  - No s_tready is asserted in IDLE. This gives one bubble cycle per block.
- Input FSM, XFER state:
  - s_tready[gnt]=core_s_tready; every other s_tready bit is 0.
  - core_s_tvalid=s_tvalid[gnt]; core_s_tdata=channel gnt slice.
  - Each handshake increments the 6-bit in_cnt.
  - The handshake at in_cnt==63 wraps in_cnt to 0 and returns the FSM to IDLE.
  - A requester that deasserts tvalid mid-block stalls the core input; the grant is never abandoned.
- Output path:
  - head = tag FIFO head.
  - When the FIFO is non-empty:
    - m_tvalid = one-hot(head) gated by core_m_tvalid.
    - m_tdata = core_m_tdata.
    - core_m_tready = m_tready[head].
  - Each handshake increments out_cnt. The handshake at out_cnt==63 pops the FIFO and wraps out_cnt to 0.
  - When the FIFO is empty, core_m_tready=0 and m_tvalid=0.
  - If core_m_tvalid=1 while the FIFO is empty, err_orphan is set and stays set until reset.
- Simultaneous events:
  - A push at IDLE and a pop at out_cnt==63 may occur in the same cycle; the FIFO count is unchanged.
  - A full FIFO with a simultaneous pop still blocks the grant in that cycle; the grant occurs next cycle.
- Latency:
  - Request to first s_tready: 1 cycle after IDLE sees valid.
  - Arbiter adds no cycles on the output path; it is combinational from core to channel.
- busy = (state==XFER) | FIFO non-empty.

Optional Feature:
- Macro: IDCT_ARB_PRIO_EN.
- When defined:
  - Adds input prio [N-1:0].
  - In IDLE, if any channel with s_tvalid & prio is high, the search considers only those channels, still upward from rr_ptr.
  - rr_ptr updates the same way as without the macro.
- When undefined: no prio port; pure round-robin as above.

Test Plan:
- Single block: channel 2 sends coefficients 0..63 with m_tready all 1 -> core_s sees 64 beats in order; 64 results appear only on m_tvalid[2]; FIFO empty after; busy returns to 0.
- Contention: channels 0, 1 and 3 all valid from reset, 3 blocks each -> grant order 0,1,3,0,1,3,0,1,3; results return in the same order on the matching one-hot m_tvalid.
- Tag full: TAG_DEPTH=2 and core_m_tready held low via m_tready=0 -> exactly 2 grants are taken; the third waits in IDLE with s_tready=0 until the first output block completes.
- Backpressure: m_tready[head] toggles 1,0 each cycle -> core_m_tready mirrors it; no beat is lost or duplicated; 64 results arrive in 128 cycles.
- Reset mid-block: assert reset_n=0 at in_cnt=30 -> outputs go to 0 immediately; after release, a new block from channel 1 is granted first (rr_ptr=0, only channel 1 valid).
- Orphan and prio: core_m_tvalid forced high with the FIFO empty -> err_orphan=1 held. With IDCT_ARB_PRIO_EN, channels 0 and 2 valid and prio=4'b0100 -> channel 2 granted first.
